// File: rtl/accel_mem_responder_pkg.sv
// Shared constants for the accelerator memory responder and the wrapper bench:
// FSM state encoding, bus address width and the value driven on a ready pulse.
package accel_mem_pkg;

    localparam int BUS_ADDR_W = 64;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_WAIT = 3'd1;
    localparam logic [2:0] S_RD_RESP = 3'd2;
    localparam logic [2:0] S_RD_ACK  = 3'd3;
    localparam logic [2:0] S_WR_WAIT = 3'd4;
    localparam logic [2:0] S_WR_RESP = 3'd5;
    localparam logic [2:0] S_WR_ACK  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_RD_WAIT = S_RD_WAIT,
        ST_RD_RESP = S_RD_RESP,
        ST_RD_ACK  = S_RD_ACK,
        ST_WR_WAIT = S_WR_WAIT,
        ST_WR_RESP = S_WR_RESP,
        ST_WR_ACK  = S_WR_ACK
    } state_e;

    // The wrapper samples its ready inputs as 64-bit words; a pulse carries 1.
    localparam logic [BUS_ADDR_W-1:0] READY_VAL = 64'd1;

endpackage

// File: rtl/accel_mem_responder_if.sv
// Read/write handshake between the accelerator wrapper (master) and the
// memory responder (slave).
interface accel_mem_responder_if
    import accel_mem_pkg::*;
#(
    parameter int DATA_WID = 32
);
    logic                  read_enable;
    logic [BUS_ADDR_W-1:0] read_addr;
    logic                  finish_read;
    logic                  write_enable;
    logic [BUS_ADDR_W-1:0] write_addr;
    logic [DATA_WID-1:0]   write_data;
    logic                  finish_write;
    logic [BUS_ADDR_W-1:0] read_ready;
    logic [DATA_WID-1:0]   read_data;
    logic [BUS_ADDR_W-1:0] write_ready;

    modport master (
        output read_enable, read_addr, finish_read,
        output write_enable, write_addr, write_data, finish_write,
        input  read_ready, read_data, write_ready
    );

    modport slave (
        input  read_enable, read_addr, finish_read,
        input  write_enable, write_addr, write_data, finish_write,
        output read_ready, read_data, write_ready
    );
endinterface

// File: rtl/accel_mem_responder_ram.sv
// Single-port word RAM with synchronous read-first access. Contents are not
// reset so preloaded data survives a responder reset.
module accel_word_ram #(
    parameter int ADDR_WID = 12,
    parameter int DATA_WID = 32
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_WID-1:0] addr,
    input  logic [DATA_WID-1:0] wdata,
    output logic [DATA_WID-1:0] rdata
);
    logic [DATA_WID-1:0] mem_q [0:(1<<ADDR_WID)-1];
    logic [DATA_WID-1:0] rdata_q;

    // Write the addressed word when enabled; always register the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/accel_mem_responder.sv
// Memory-side responder for the accelerator wrapper: serves word reads and
// writes from a local RAM after a programmable latency, one ready pulse per
// word, with a preload port usable while idle.
module accel_mem_responder
    import accel_mem_pkg::*;
#(
    parameter int                    ADDR_WID = 12,
    parameter int                    DATA_WID = 32,
    parameter int                    LATENCY  = 4,
    parameter logic [BUS_ADDR_W-1:0] MEM_BASE = 64'h0
) (
    input  logic                clk,
    input  logic                reset,
    accel_mem_responder_if.slave bus,
    input  logic                ld_en,
    input  logic [ADDR_WID-1:0] ld_addr,
    input  logic [DATA_WID-1:0] ld_data,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count,
    output logic                addr_err
);
    localparam int                 LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0]   LAT_LOAD = LAT_W'(LATENCY - 1);

    state_e                  state_q, state_d;
    logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
    logic [BUS_ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_WID-1:0]     wdata_q, wdata_d;
    logic [DATA_WID-1:0]     read_data_q, read_data_d;
    logic [31:0]             rd_count_q, rd_count_d;
    logic [31:0]             wr_count_q, wr_count_d;
    logic                    addr_err_q, addr_err_d;
    logic                    rd_done;
    logic                    wr_commit;
    logic                    ram_we;
    logic [ADDR_WID-1:0]     ram_addr;
    logic [DATA_WID-1:0]     ram_wdata;
    logic [DATA_WID-1:0]     ram_rdata;

    // A byte address maps to the RAM only at or above MEM_BASE and below
    // MEM_BASE + 4 * depth.
    function automatic logic addr_in_range(input logic [BUS_ADDR_W-1:0] a);
        return (a >= MEM_BASE) && (((a - MEM_BASE) >> (ADDR_WID + 2)) == '0);
    endfunction

    function automatic logic [ADDR_WID-1:0] word_idx(input logic [BUS_ADDR_W-1:0] a);
        return ADDR_WID'((a - MEM_BASE) >> 2);
    endfunction

    // Control state and read-side outputs; reset leaves the RAM untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            read_data_q <= '0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            read_data_q <= read_data_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Latched request address and write word; only meaningful while busy.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Next-state logic: request acceptance, latency countdown, ack handling.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_done   = 1'b0;
        wr_commit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.read_enable) begin
                    state_d   = ST_RD_WAIT;
                    addr_d    = bus.read_addr;
                    lat_cnt_d = LAT_LOAD;
                end else if (bus.write_enable) begin
                    state_d   = ST_WR_WAIT;
                    addr_d    = bus.write_addr;
                    wdata_d   = bus.write_data;
                    lat_cnt_d = LAT_LOAD;
                end
            end
            ST_RD_WAIT: begin
                if (!bus.read_enable) begin
                    state_d = ST_IDLE;
                end else if (lat_cnt_q == '0) begin
                    state_d = ST_RD_RESP;
                    rd_done = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            ST_RD_RESP: state_d = ST_RD_ACK;
            ST_RD_ACK: begin
                if (!bus.read_enable) begin
                    state_d = ST_IDLE;
                end else if (bus.finish_read) begin
                    state_d   = ST_RD_WAIT;
                    addr_d    = bus.read_addr;
                    lat_cnt_d = LAT_LOAD;
                end
            end
            ST_WR_WAIT: begin
                if (!bus.write_enable) begin
                    state_d = ST_IDLE;
                end else if (lat_cnt_q == '0) begin
                    state_d   = ST_WR_RESP;
                    wr_commit = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            ST_WR_RESP: state_d = ST_WR_ACK;
            ST_WR_ACK: begin
                if (!bus.write_enable) begin
                    state_d = ST_IDLE;
                end else if (bus.finish_write) begin
                    state_d   = ST_WR_WAIT;
                    addr_d    = bus.write_addr;
                    wdata_d   = bus.write_data;
                    lat_cnt_d = LAT_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath: RAM port mux, read capture, counters, error flag.
    // The RAM is addressed from the next latched address so its registered
    // output already holds the requested word during the whole wait phase.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = word_idx(addr_d);
        ram_wdata = wdata_q;
        if (state_q == ST_IDLE && ld_en) begin
            ram_we    = 1'b1;
            ram_addr  = ld_addr;
            ram_wdata = ld_data;
        end else if (wr_commit && addr_in_range(addr_q)) begin
            ram_we   = 1'b1;
            ram_addr = word_idx(addr_q);
        end

        read_data_d = read_data_q;
        if (rd_done) begin
            read_data_d = addr_in_range(addr_q) ? ram_rdata : '0;
        end

        addr_err_d = addr_err_q | ((rd_done | wr_commit) & ~addr_in_range(addr_q));
        rd_count_d = rd_count_q + ((state_q == ST_RD_RESP) ? 32'd1 : 32'd0);
        wr_count_d = wr_count_q + ((state_q == ST_WR_RESP) ? 32'd1 : 32'd0);
    end

    assign bus.read_ready  = (state_q == ST_RD_RESP) ? READY_VAL : '0;
    assign bus.write_ready = (state_q == ST_WR_RESP) ? READY_VAL : '0;
    assign bus.read_data   = read_data_q;
    assign rd_count        = rd_count_q;
    assign wr_count        = wr_count_q;
    assign addr_err        = addr_err_q;

    accel_word_ram #(
        .ADDR_WID (ADDR_WID),
        .DATA_WID (DATA_WID)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );
endmodule

// File: tb/tb_accel_mem_responder.sv
// Scoreboard bench for accel_mem_responder: a wrapper-like driver issues read
// and write bursts and pushes expected words and pulse cycles; a monitor pops
// and compares on every ready pulse.
module tb_accel_mem_responder;
    import accel_mem_pkg::*;

    localparam int          AW   = 12;
    localparam int          DW   = 32;
    localparam int          LAT  = 4;
    localparam logic [63:0] BASE = 64'h0;
    localparam int          DEPTH = 1 << AW;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;
    logic          addr_err;

    accel_mem_responder_if #(.DATA_WID(DW)) bus();

    accel_mem_responder #(
        .ADDR_WID (AW),
        .DATA_WID (DW),
        .LATENCY  (LAT),
        .MEM_BASE (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .rd_count (rd_count),
        .wr_count (wr_count),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: flat word array plus expected counters and error flag.
    logic [DW-1:0] mdl [0:DEPTH-1];
    int            exp_rd = 0;
    int            exp_wr = 0;
    bit            exp_err = 1'b0;
    exp_t          rq[$];
    exp_t          wq[$];
    logic [63:0]   ba[$];
    logic [DW-1:0] bd[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit in_map(input logic [63:0] a);
        return (a >= BASE) && (((a - BASE) / 4) < 64'(DEPTH));
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [63:0] a);
        if (!in_map(a)) begin
            exp_err = 1'b1;
            return '0;
        end
        return mdl[int'((a - BASE) / 4)];
    endfunction

    task automatic model_write(input logic [63:0] a, input logic [DW-1:0] d);
        if (!in_map(a)) exp_err = 1'b1;
        else mdl[int'((a - BASE) / 4)] = d;
    endtask

    // Monitor: every ready pulse must match the oldest expectation.
    bit   prev_r = 1'b0;
    bit   prev_w = 1'b0;
    exp_t me;
    always @(negedge clk) begin
        if (reset) begin
            prev_r = 1'b0;
            prev_w = 1'b0;
        end else begin
            if (bus.read_ready != 64'd0) begin
                check("rd_ready_value", bus.read_ready, 64'd1);
                check("rd_ready_single_cycle", 64'(prev_r), 64'd0);
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read_ready: got pulse at cycle %0d, required none", cyc);
                end else begin
                    me = rq.pop_front();
                    check("rd_data", 64'(bus.read_data), 64'(me.data));
                    check("rd_latency", 64'(cyc), 64'(me.cyc));
                end
            end
            if (bus.write_ready != 64'd0) begin
                check("wr_ready_value", bus.write_ready, 64'd1);
                check("wr_ready_single_cycle", 64'(prev_w), 64'd0);
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write_ready: got pulse at cycle %0d, required none", cyc);
                end else begin
                    me = wq.pop_front();
                    check("wr_latency", 64'(cyc), 64'(me.cyc));
                end
            end
            prev_r = (bus.read_ready != 64'd0);
            prev_w = (bus.write_ready != 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input bit is_rd);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (is_rd && bus.read_ready != 64'd0) return;
            if (!is_rd && bus.write_ready != 64'd0) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no ready pulse in 50 cycles, required one", is_rd ? "rd" : "wr");
    endtask

    task automatic preload(input int idx, input logic [DW-1:0] d);
        ld_en   = 1'b1;
        ld_addr = AW'(idx);
        ld_data = d;
        tick();
        ld_en   = 1'b0;
        mdl[idx] = d;
    endtask

    // Wrapper-style read burst over the addresses in ba.
    task automatic read_burst();
        exp_t e;
        for (int i = 0; i < ba.size(); i++) begin
            if (i == 0) bus.read_enable = 1'b1;
            else        bus.finish_read = 1'b1;
            bus.read_addr = ba[i];
            e.data = model_read(ba[i]);
            e.cyc  = cyc + LAT + 1;
            rq.push_back(e);
            exp_rd++;
            if (i > 0) begin
                tick();
                bus.finish_read = 1'b0;
            end
            wait_pulse(1'b1);
            tick();
        end
        bus.read_enable = 1'b0;
        tick();
    endtask

    // Wrapper-style write burst over ba/bd.
    task automatic write_burst();
        exp_t e;
        for (int i = 0; i < ba.size(); i++) begin
            if (i == 0) bus.write_enable = 1'b1;
            else        bus.finish_write = 1'b1;
            bus.write_addr = ba[i];
            bus.write_data = bd[i];
            model_write(ba[i], bd[i]);
            e.data = bd[i];
            e.cyc  = cyc + LAT + 1;
            wq.push_back(e);
            exp_wr++;
            if (i > 0) begin
                tick();
                bus.finish_write = 1'b0;
            end
            wait_pulse(1'b0);
            tick();
        end
        bus.write_enable = 1'b0;
        tick();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_rd_count"}, 64'(rd_count), 64'(exp_rd));
        check({tag, "_wr_count"}, 64'(wr_count), 64'(exp_wr));
        check({tag, "_addr_err"}, 64'(addr_err), 64'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        int   w;
        reset = 1'b1;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        bus.read_enable  = 1'b0;
        bus.read_addr    = '0;
        bus.finish_read  = 1'b0;
        bus.write_enable = 1'b0;
        bus.write_addr   = '0;
        bus.write_data   = '0;
        bus.finish_write = 1'b0;
        tick(); tick(); tick();
        check("rst_read_ready", bus.read_ready, 64'd0);
        check("rst_write_ready", bus.write_ready, 64'd0);
        check("rst_read_data", 64'(bus.read_data), 64'd0);
        check_counts("rst");
        reset = 1'b0;
        tick();

        // Preload: the four directed words plus a random region 64..127.
        for (int i = 0; i < 4; i++) preload(i, DW'((i + 1) * 10));
        for (int i = 64; i < 128; i++) preload(i, $urandom());

        ba = {}; for (int i = 0; i < 4; i++) ba.push_back(64'(4 * i));
        read_burst();
        check_counts("rd4");

        ba = {}; bd = {};
        ba.push_back(64'h100); bd.push_back(32'hA);
        ba.push_back(64'h104); bd.push_back(32'hB);
        ba.push_back(64'h108); bd.push_back(32'hC);
        write_burst();
        check_counts("wr3");
        read_burst();
        check_counts("rdback");

        // Random bursts over the preloaded regions.
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 4);
            ba = {}; bd = {};
            for (int k = 0; k < n; k++) begin
                w = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(64, 127);
                if (it % 2 == 0) w = $urandom_range(64, 127);
                ba.push_back(BASE + 64'(4 * w));
                bd.push_back($urandom());
            end
            if (it % 2 == 0) write_burst();
            else             read_burst();
        end
        check_counts("rand");

        // Out-of-range read returns zero and sets the sticky error.
        ba = {}; ba.push_back(64'(4 * DEPTH));
        read_burst();
        check_counts("oor");
        ba = {}; for (int i = 0; i < 4; i++) ba.push_back(64'(4 * i));
        read_burst();
        check_counts("oor_sticky");

        // Abort: drop read_enable during the wait phase.
        bus.read_enable = 1'b1;
        bus.read_addr   = 64'd0;
        tick(); tick();
        bus.read_enable = 1'b0;
        for (int i = 0; i < LAT + 4; i++) tick();
        check_counts("abort");
        check("abort_state_idle", 64'(dut.state_q), 64'(S_IDLE));

        // Read and write raised together: read first, write after read drops.
        bus.write_enable = 1'b1;
        bus.write_addr   = 64'h200;
        bus.write_data   = $urandom();
        ba = {}; ba.push_back(64'd4);
        read_burst();
        model_write(64'h200, bus.write_data);
        e.data = bus.write_data;
        e.cyc  = cyc + LAT + 1;
        wq.push_back(e);
        exp_wr++;
        wait_pulse(1'b0);
        tick();
        bus.write_enable = 1'b0;
        tick();
        ba = {}; ba.push_back(64'h200);
        read_burst();
        check_counts("both");

        // Asynchronous reset in the middle of a read wait.
        bus.read_enable = 1'b1;
        bus.read_addr   = 64'd0;
        tick(); tick();
        #3;
        reset = 1'b1;
        #1;
        check("midrst_read_ready", bus.read_ready, 64'd0);
        check("midrst_read_data", 64'(bus.read_data), 64'd0);
        check("midrst_rd_count", 64'(rd_count), 64'd0);
        check("midrst_addr_err", 64'(addr_err), 64'd0);
        rq.delete();
        wq.delete();
        exp_rd = 0;
        exp_wr = 0;
        exp_err = 1'b0;
        bus.read_enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        ba = {}; ba.push_back(64'd0);
        read_burst();
        check_counts("postrst");

        tick(); tick();
        check("final_rd_queue_empty", 64'(rq.size()), 64'd0);
        check("final_wr_queue_empty", 64'(wq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
